window_sorter: RTL and testbench
================================

# window_sorter

Streaming window sorter for the adaptive median filter datapath. It accepts up to WINDOW pixel samples one per cycle and keeps them in a parallel insertion-sorted register array. It then presents Zmin, Zmed, Zmax and the sample count to the filter decision stage over a valid/ready handshake. It generalises the single two-input magnitude compare into a parametrised, stateful ordering engine with partial-window support.

## Interface
- DATA_WIDTH, 8: bits per sample.
- WINDOW, 9: maximum samples per window; odd, 3..49.
- CNT_W, $clog2(WINDOW+1): width of count values (derived, not overridden).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present on in_data.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DATA_WIDTH  sample.
- in_last  in  1  marks the final sample of a short window.
- out_valid  out  1  window result available.
- out_ready  in  1  downstream consumes the result.
- out_min  out  DATA_WIDTH  smallest sample.
- out_med  out  DATA_WIDTH  median, lower median for even counts.
- out_max  out  DATA_WIDTH  largest sample.
- out_count  out  CNT_W  samples in the window, 1..WINDOW.

## Operation
- States:
  - FILL: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept occurs when in_valid && in_ready. Each accept inserts the sample and increments count.
- Slot array slot[0..WINDOW-1] is ascending. Slots at index >= count are treated as +infinity.
- Insertion rule:
  - lt_i = (i >= count) || (x < slot[i]).
  - If lt_i, slot[i] takes slot[i-1] when i>0 && lt_{i-1}, otherwise x.
  - If !lt_i, slot[i] is held.
  - Writes are gated to i <= count.
- Ties: the strict compare places a new equal sample after existing equal samples, so insertion is stable.
- FILL→DONE on an accept when count+1 == WINDOW or in_last=1. in_last on the WINDOW-th sample is redundant and harmless.
- DONE→FILL on out_ready. count clears to 0 and slot contents become don't-care.
- In DONE, with n = count:
  - out_min = slot[0].
  - out_max = slot[n-1].
  - out_med = slot[(n-1)>>1].
  - out_count = n.
- Outside DONE, out_min/out_med/out_max/out_count drive 0.
- in_valid is ignored while in_ready=0; no sample is lost or counted.

## Timing
- Reset: state FILL, count 0, in_ready=1, out_valid=0, all out_* data 0. Slot contents are undefined.
- Reset mid-window or during DONE discards the window immediately (asynchronous). out_valid drops without waiting for a clock.
- Latency: out_valid rises on the cycle after the final accept.
- out_* stay stable for the whole of DONE until the handshake.
- Result handshake completes on the edge where out_valid && out_ready. in_ready returns on the next cycle.
- Minimum period per full window is WINDOW+1 cycles.
- No combinational path exists from in_valid or out_ready to in_ready or out_valid; both are decoded from the state register only.

## Configuration
- WINDOW_SORTER_SIGNED_EN defined: all slot compares treat samples as two's-complement.
- WINDOW_SORTER_SIGNED_EN undefined (default): all slot compares are unsigned magnitude.
- The macro changes compare semantics only; ports and timing are identical.

## Structure
- Shared package amf_pkg holds:
  - FILL/DONE state encoding localparams.
  - a clog2 helper.
  - the default DATA_WIDTH.
- Sub-module sort_slot: one register plus its lt compare and next-value mux, instantiated WINDOW times in a generate loop.
- The top level holds the FSM, count, and the output muxes.

## Test plan
- WINDOW=9, DATA_WIDTH=8, samples 5,3,9,1,7,2,8,6,4 -> out_valid one cycle after the 9th accept; min=1, med=5, max=9, count=9.
- Nine samples all 7 -> min=med=max=7, count=9. Additionally check slot order stability with a 7,7,3 prefix.
- Samples 10,40,20,30 with in_last on 30 -> count=4, min=10, med=20, max=40.
- Result ready: out_ready held low 5 cycles with in_valid=1 -> out_valid and out_* stable, in_ready=0, no extra accepts. Raise out_ready -> in_ready=1 the next cycle and a fresh window forms.
- Reset pulse after 4 samples accepted -> out_valid=0 and in_ready=1 immediately. The next 9 samples (5,3,9,1,7,2,8,6,4) yield min=1, med=5, max=9 with no stale values.
- WINDOW=3, samples 8'hFF, 8'h01, 8'h80:
  - WINDOW_SORTER_SIGNED_EN defined -> min=80, med=FF, max=01.
  - WINDOW_SORTER_SIGNED_EN undefined -> min=01, med=80, max=FF.

Source files
------------

// File: rtl/amf_pkg.sv
// Shared definitions for the adaptive median filter datapath: state encoding,
// a constant clog2 helper and the default sample width.
package amf_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic FILL_ENC = 1'b0;
    localparam logic DONE_ENC = 1'b1;

    typedef enum logic {
        ST_FILL = FILL_ENC,
        ST_DONE = DONE_ENC
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/window_sorter_if.sv
// Sample-in / result-out handshake bundle of the window sorter.
interface window_sorter_if import amf_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int WINDOW     = 9
);
    localparam int CNT_W = clog2(WINDOW + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_min;
    logic [DATA_WIDTH-1:0] out_med;
    logic [DATA_WIDTH-1:0] out_max;
    logic [CNT_W-1:0]      out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_min, out_med, out_max, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_min, out_med, out_max, out_count
    );

endinterface

// File: rtl/window_sorter_sort_slot.sv
// One position of the insertion-sorted array: register, "new sample goes before me"
// compare and next-value mux. WINDOW_SORTER_SIGNED_EN selects two's-complement compares.
module sort_slot import amf_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic                  empty,
    input  logic                  we,
    input  logic                  lt_prev,
    input  logic [DATA_WIDTH-1:0] prev_val,
    output logic                  lt,
    output logic [DATA_WIDTH-1:0] slot
);
    logic [DATA_WIDTH-1:0] slot_q, slot_d;
    logic                  x_lt;

`ifdef WINDOW_SORTER_SIGNED_EN
    logic signed [DATA_WIDTH-1:0] x_s, slot_s;
    assign x_s    = x;
    assign slot_s = slot_q;
    assign x_lt   = x_s < slot_s;
`else
    assign x_lt = x < slot_q;
`endif

    // Strict compare keeps equal samples in arrival order; unused slots act as +infinity.
    assign lt = empty || x_lt;

    always_comb begin
        slot_d = slot_q;
        if (we && lt) begin
            slot_d = lt_prev ? prev_val : x;
        end
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign slot = slot_q;

endmodule

// File: rtl/window_sorter.sv
// Streaming window sorter: collects up to WINDOW samples into a parallel insertion-sorted
// array and reports min/median/max/count. Build option: WINDOW_SORTER_SIGNED_EN.
module window_sorter import amf_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int WINDOW     = 9
) (
    input  logic           clk,
    input  logic           rst,
    window_sorter_if.slave bus
);
    localparam int               CNT_W    = clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  accept;
    logic [WINDOW-1:0]     lt;
    logic [DATA_WIDTH-1:0] slot_val [WINDOW];
    logic [CNT_W-1:0]      max_idx;
    logic [CNT_W-1:0]      med_idx;

    assign accept = bus.in_valid && (state_q == ST_FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Handshake flags decode from the state register only.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_FILL: begin
                bus.in_ready = 1'b1;
                if (accept) begin
                    count_d = count_q + CNT_W'(1);
                    if ((count_q == LAST_CNT) || bus.in_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_FILL;
                    count_d = '0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    for (genvar i = 0; i < WINDOW; i++) begin : g_slot
        localparam logic [CNT_W-1:0] IDX = CNT_W'(i);
        logic                  lt_prev;
        logic [DATA_WIDTH-1:0] prev_val;
        logic                  empty;
        logic                  we;
        if (i == 0) begin : g_head
            assign lt_prev  = 1'b0;
            assign prev_val = '0;
            assign empty    = (count_q == '0);
            assign we       = accept;
        end else begin : g_body
            assign lt_prev  = lt[i-1];
            assign prev_val = slot_val[i-1];
            assign empty    = (IDX >= count_q);
            assign we       = accept && (IDX <= count_q);
        end
        sort_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk      (clk),
            .x        (bus.in_data),
            .empty    (empty),
            .we       (we),
            .lt_prev  (lt_prev),
            .prev_val (prev_val),
            .lt       (lt[i]),
            .slot     (slot_val[i])
        );
    end

    always_comb begin
        max_idx       = count_q - CNT_W'(1);
        med_idx       = max_idx >> 1;
        bus.out_min   = '0;
        bus.out_med   = '0;
        bus.out_max   = '0;
        bus.out_count = '0;
        if (state_q == ST_DONE) begin
            bus.out_min   = slot_val[0];
            bus.out_med   = slot_val[med_idx];
            bus.out_max   = slot_val[max_idx];
            bus.out_count = count_q;
        end
    end

endmodule

// File: tb/tb_window_sorter.sv
// Directed bench for window_sorter: WINDOW=9 instance for the main scenarios and a
// WINDOW=3 instance for the compare-sign check.
module tb_window_sorter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    window_sorter_if #(.DATA_WIDTH(8), .WINDOW(9)) b9 ();
    window_sorter_if #(.DATA_WIDTH(8), .WINDOW(3)) b3 ();

    window_sorter #(.DATA_WIDTH(8), .WINDOW(9)) u_dut9 (
        .clk (clk),
        .rst (rst),
        .bus (b9)
    );

    window_sorter #(.DATA_WIDTH(8), .WINDOW(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push9(input logic [7:0] x, input logic last);
        b9.in_valid = 1'b1;
        b9.in_data  = x;
        b9.in_last  = last;
        @(posedge clk);
        #1;
        b9.in_valid = 1'b0;
        b9.in_last  = 1'b0;
    endtask

    task automatic push3(input logic [7:0] x, input logic last);
        b3.in_valid = 1'b1;
        b3.in_data  = x;
        b3.in_last  = last;
        @(posedge clk);
        #1;
        b3.in_valid = 1'b0;
        b3.in_last  = 1'b0;
    endtask

    task automatic release9();
        b9.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b9.out_ready = 1'b0;
    endtask

    task automatic check_result9(input string tag, input logic [7:0] mn, input logic [7:0] md,
                                 input logic [7:0] mx, input logic [3:0] cnt);
        check({tag, "_valid"}, 32'(b9.out_valid), 32'd1);
        check({tag, "_inrdy"}, 32'(b9.in_ready), 32'd0);
        check({tag, "_min"},   32'(b9.out_min), 32'(mn));
        check({tag, "_med"},   32'(b9.out_med), 32'(md));
        check({tag, "_max"},   32'(b9.out_max), 32'(mx));
        check({tag, "_count"}, 32'(b9.out_count), 32'(cnt));
    endtask

    initial begin
        logic [7:0] seq [9];
        checks = 0;
        errors = 0;
        seq = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd6, 8'd4};
        rst = 1'b1;
        b9.in_valid = 1'b0; b9.in_data = '0; b9.in_last = 1'b0; b9.out_ready = 1'b0;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.in_last = 1'b0; b3.out_ready = 1'b0;

        #2;
        check("rst_inrdy", 32'(b9.in_ready), 32'd1);
        check("rst_valid", 32'(b9.out_valid), 32'd0);
        check("rst_min",   32'(b9.out_min), 32'd0);
        check("rst_max",   32'(b9.out_max), 32'd0);
        check("rst_count", 32'(b9.out_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full window of distinct samples.
        for (int i = 0; i < 8; i++) push9(seq[i], 1'b0);
        check("full_pre_valid", 32'(b9.out_valid), 32'd0);
        push9(seq[8], 1'b0);
        check_result9("full", 8'd1, 8'd5, 8'd9, 4'd9);
        release9();
        check("hs_valid", 32'(b9.out_valid), 32'd0);
        check("hs_inrdy", 32'(b9.in_ready), 32'd1);
        check("hs_count", 32'(b9.out_count), 32'd0);

        // All-equal window, then a short tie prefix.
        for (int i = 0; i < 9; i++) push9(8'd7, 1'b0);
        check_result9("equal", 8'd7, 8'd7, 8'd7, 4'd9);
        release9();
        push9(8'd7, 1'b0);
        push9(8'd7, 1'b0);
        push9(8'd3, 1'b1);
        check_result9("tie", 8'd3, 8'd7, 8'd7, 4'd3);
        release9();

        // Partial window with even count: lower median.
        push9(8'd10, 1'b0);
        push9(8'd40, 1'b0);
        push9(8'd20, 1'b0);
        push9(8'd30, 1'b1);
        check_result9("short", 8'd10, 8'd20, 8'd40, 4'd4);
        release9();

        // Backpressure: result held, new samples refused.
        for (int i = 0; i < 9; i++) push9(8'(20 - i), 1'b0);
        check_result9("bp0", 8'd12, 8'd16, 8'd20, 4'd9);
        b9.in_valid = 1'b1;
        b9.in_data  = 8'd0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_result9("bp_hold", 8'd12, 8'd16, 8'd20, 4'd9);
        end
        b9.in_valid = 1'b0;
        release9();
        check("bp_rel_inrdy", 32'(b9.in_ready), 32'd1);
        check("bp_rel_valid", 32'(b9.out_valid), 32'd0);
        push9(8'd50, 1'b0);
        push9(8'd60, 1'b0);
        push9(8'd70, 1'b1);
        check_result9("bp_next", 8'd50, 8'd60, 8'd70, 4'd3);
        release9();

        // Reset part-way through a window.
        for (int i = 0; i < 4; i++) push9(8'(100 + i), 1'b0);
        rst = 1'b1;
        #1;
        check("rstmid_inrdy", 32'(b9.in_ready), 32'd1);
        check("rstmid_valid", 32'(b9.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) push9(seq[i], 1'b0);
        check("rstmid_pre_valid", 32'(b9.out_valid), 32'd0);
        push9(seq[8], 1'b0);
        check_result9("rstmid", 8'd1, 8'd5, 8'd9, 4'd9);

        // Asynchronous reset while a result is waiting.
        #2;
        rst = 1'b1;
        #1;
        check("rstdone_valid", 32'(b9.out_valid), 32'd0);
        check("rstdone_inrdy", 32'(b9.in_ready), 32'd1);
        check("rstdone_min",   32'(b9.out_min), 32'd0);
        check("rstdone_count", 32'(b9.out_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Compare sign on the three-sample instance.
        push3(8'hFF, 1'b0);
        push3(8'h01, 1'b0);
        check("w3_pre_valid", 32'(b3.out_valid), 32'd0);
        push3(8'h80, 1'b0);
        check("w3_valid", 32'(b3.out_valid), 32'd1);
        check("w3_count", 32'(b3.out_count), 32'd3);
`ifdef WINDOW_SORTER_SIGNED_EN
        check("w3_min", 32'(b3.out_min), 32'h80);
        check("w3_med", 32'(b3.out_med), 32'hFF);
        check("w3_max", 32'(b3.out_max), 32'h01);
`else
        check("w3_min", 32'(b3.out_min), 32'h01);
        check("w3_med", 32'(b3.out_med), 32'h80);
        check("w3_max", 32'(b3.out_max), 32'hFF);
`endif
        b3.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b3.out_ready = 1'b0;
        check("w3_hs_inrdy", 32'(b3.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
